// File: rtl/dcm_prog.sv
// dcm_prog -- programmable tick generator.
//
// Produces two single-cycle clock-enable pulses in the clock domain:
//   clock_1 : fixed rate, one pulse every FIX_DIV cycles
//   clock_2 : programmable rate, one pulse every BASE_DIV << sel cycles
// Rate changes requested through update/prog_in are held until the next
// clock_2 period boundary, so no period is ever truncated.
//
// Ports:
//   clock     in             system clock
//   reset     in             synchronous, active-high reset
//   update    in             request to load prog_in
//   prog_in   in  [SEL_W]    requested rate selector
//   clock_1   out            fixed-rate pulse
//   clock_2   out            programmable-rate pulse
//   prog_out  out [SEL_W]    selector currently in effect
//   pending   out            a request is captured but not yet applied
//   sq_1/sq_2 out            50% square waves toggling on each pulse
//                            (present only when DCM_SQUARE_EN is defined)
//
// Optional feature macro: DCM_SQUARE_EN
//
// Rate-change FSM:
//   state   | meaning
//   ST_IDLE | no request outstanding, pending = 0
//   ST_WAIT | request held in pend_sel_q until the clock_2 wrap, pending = 1

module dcm_prog #(
   parameter int CNT_W     = 32,
   parameter int SEL_W     = 3,
   parameter int FIX_DIV   = 10_000_000,
   parameter int BASE_DIV  = 10_000_000,
   parameter int RESET_SEL = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             update,
   input  logic [SEL_W-1:0] prog_in,
   output logic             clock_1,
   output logic             clock_2,
   output logic [SEL_W-1:0] prog_out,
   output logic             pending
`ifdef DCM_SQUARE_EN
   ,
   output logic             sq_1,
   output logic             sq_2
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] FIX_LAST = CNT_W'(FIX_DIV - 1);
   localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_DIV);
   localparam logic [SEL_W-1:0] RST_SEL  = SEL_W'(RESET_SEL);

   state_t           state_q;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic [CNT_W-1:0] cnt2_q, cnt2_d;
   logic [CNT_W-1:0] period2, period2_last;
   logic [SEL_W-1:0] active_sel_q;
   logic [SEL_W-1:0] pend_sel_q;
   logic             clock_1_q, clock_2_q, pending_q;
   logic             wrap1, wrap2;

   // Period follows the selector in effect, so a new rate starts with the
   // first full period after the boundary at which it was applied.
   assign period2      = BASE_CNT << active_sel_q;
   assign period2_last = period2 - ONE;

   assign wrap1  = (cnt1_q == FIX_LAST);
   assign wrap2  = (cnt2_q == period2_last);
   assign cnt1_d = wrap1 ? '0 : cnt1_q + ONE;
   assign cnt2_d = wrap2 ? '0 : cnt2_q + ONE;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt1_q       <= '0;
         cnt2_q       <= '0;
         clock_1_q    <= 1'b0;
         clock_2_q    <= 1'b0;
         active_sel_q <= RST_SEL;
         pend_sel_q   <= RST_SEL;
         pending_q    <= 1'b0;
      end else begin
         cnt1_q    <= cnt1_d;
         cnt2_q    <= cnt2_d;
         clock_1_q <= wrap1;
         clock_2_q <= wrap2;
         case (state_q)
            ST_IDLE: begin
               if (wrap2) begin
                  // A request landing on the boundary is applied directly.
                  if (update) active_sel_q <= prog_in;
               end else if (update) begin
                  pend_sel_q <= prog_in;
                  pending_q  <= 1'b1;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wrap2) begin
                  // A request on the boundary itself overrides the held one.
                  active_sel_q <= update ? prog_in : pend_sel_q;
                  pending_q    <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (update) begin
                  pend_sel_q <= prog_in;
               end
            end
            default: begin
               pending_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign clock_1  = clock_1_q;
   assign clock_2  = clock_2_q;
   assign prog_out = active_sel_q;
   assign pending  = pending_q;

`ifdef DCM_SQUARE_EN
   logic sq_1_q, sq_2_q;

   // Toggle on the same edge that raises the pulse; rate changes only move
   // the boundary, so sq_2 never sees a short phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         sq_1_q <= 1'b0;
         sq_2_q <= 1'b0;
      end else begin
         if (wrap1) sq_1_q <= ~sq_1_q;
         if (wrap2) sq_2_q <= ~sq_2_q;
      end
   end

   assign sq_1 = sq_1_q;
   assign sq_2 = sq_2_q;
`endif

endmodule

// File: tb/tb_dcm_prog.sv
module tb_dcm_prog;

   localparam int CNT_W = 8;
   localparam int SEL_W = 2;
   localparam int FIX   = 4;
   localparam int BASE  = 3;
   localparam int RSEL  = 0;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             update = 1'b0;
   logic [SEL_W-1:0] prog_in = '0;
   logic             clock_1, clock_2, pending;
   logic [SEL_W-1:0] prog_out;
`ifdef DCM_SQUARE_EN
   logic             sq_1, sq_2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: t counts edges since reset release; the clock_2
   // boundaries are tracked as absolute edge numbers.
   int t, next2, msel, mpend, mpsel;
   int exp_c1, exp_c2, m_sq1, m_sq2;

   dcm_prog #(
      .CNT_W(CNT_W), .SEL_W(SEL_W), .FIX_DIV(FIX), .BASE_DIV(BASE),
      .RESET_SEL(RSEL)
   ) dut (
      .clock(clock), .reset(reset), .update(update), .prog_in(prog_in),
      .clock_1(clock_1), .clock_2(clock_2), .prog_out(prog_out),
      .pending(pending)
`ifdef DCM_SQUARE_EN
      , .sq_1(sq_1), .sq_2(sq_2)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic step(input bit upd, input int pin);
      update  = upd;
      prog_in = pin[SEL_W-1:0];
      @(posedge clock);
      if (reset) begin
         t = 0; msel = RSEL; next2 = BASE << RSEL; mpend = 0; mpsel = 0;
         exp_c1 = 0; exp_c2 = 0; m_sq1 = 0; m_sq2 = 0;
      end else begin
         t++;
         exp_c1 = (t % FIX == 0) ? 1 : 0;
         if (exp_c1 == 1) m_sq1 ^= 1;
         if (t == next2) begin
            exp_c2 = 1;
            m_sq2 ^= 1;
            if (upd) msel = pin;
            else if (mpend == 1) msel = mpsel;
            mpend = 0;
            next2 = t + (BASE << msel);
         end else begin
            exp_c2 = 0;
            if (upd) begin
               mpend = 1;
               mpsel = pin;
            end
         end
      end
      #1;
      chk("clock_1", 32'(clock_1), 32'(exp_c1));
      chk("clock_2", 32'(clock_2), 32'(exp_c2));
      chk("prog_out", 32'(prog_out), 32'(msel));
      chk("pending", 32'(pending), 32'(mpend));
`ifdef DCM_SQUARE_EN
      chk("sq_1", 32'(sq_1), 32'(m_sq1));
      chk("sq_2", 32'(sq_2), 32'(m_sq2));
`endif
   endtask

   initial begin
      t = 0; next2 = BASE; msel = RSEL; mpend = 0; mpsel = 0;
      exp_c1 = 0; exp_c2 = 0; m_sq1 = 0; m_sq2 = 0;

      // Reset and free-running rates
      reset = 1'b1;
      step(0, 0);
      step(0, 0);
      reset = 1'b0;
      while (t < 24) step(0, 0);

      // Request sel 2 in cycle 4, applied at the cycle-6 boundary
      reset = 1'b1;
      step(0, 0);
      reset = 1'b0;
      while (t < 4) step(0, 0);
      chk("c1_at_4", 32'(clock_1), 32'd1);
      step(1, 2);
      chk("pend_at_5", 32'(pending), 32'd1);
      step(0, 0);
      chk("c2_at_6", 32'(clock_2), 32'd1);
      chk("sel_at_6", 32'(prog_out), 32'd2);
      chk("pend_at_6", 32'(pending), 32'd0);
      while (t < 18) step(0, 0);
      chk("c2_at_18", 32'(clock_2), 32'd1);
      while (t < 30) step(0, 0);
      chk("c2_at_30", 32'(clock_2), 32'd1);

      // Two requests in one period: last one wins
      while (t < 31) step(0, 0);
      step(1, 1);
      while (t < 34) step(0, 0);
      step(1, 3);
      while (t < 42) step(0, 0);
      chk("c2_at_42", 32'(clock_2), 32'd1);
      chk("sel_at_42", 32'(prog_out), 32'd3);

      // Request on the wrap edge itself: applied immediately, never pending
      while (t < 65) step(0, 0);
      chk("pend_pre_66", 32'(pending), 32'd0);
      step(1, 1);
      chk("c2_at_66", 32'(clock_2), 32'd1);
      chk("sel_at_66", 32'(prog_out), 32'd1);
      chk("pend_at_66", 32'(pending), 32'd0);
      while (t < 72) step(0, 0);
      chk("c2_at_72", 32'(clock_2), 32'd1);

      // Reset while a request is pending
      step(1, 2);
      chk("pend_before_rst", 32'(pending), 32'd1);
      reset = 1'b1;
      step(0, 0);
      step(0, 0);
      chk("pend_after_rst", 32'(pending), 32'd0);
      chk("sel_after_rst", 32'(prog_out), 32'd0);
      reset = 1'b0;
      while (t < 3) step(0, 0);
      chk("c2_3_after_rst", 32'(clock_2), 32'd1);

      // Randomized requests and occasional resets
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 149) == 0);
         step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
      end
      reset = 1'b0;
      for (int i = 0; i < 60; i++) step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
